// File: rtl/muldiv_ctrl.sv
// HI/LO multiply-divide controller: single-cycle 32x32 multiply, 32-step restoring
// divide, same-cycle MTHI/MTLO writes, with flush and a one-cycle DONE write-back.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        hi_write,
  output logic        lo_write,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNTW = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [1:0]        state, state_nxt;
  logic [CNTW-1:0]   cnt;
  logic [XLEN-1:0]   op_a, op_b;
  logic              is_signed;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   quo, rem, dvsr;
  logic [XLEN-1:0]   res_hi, res_lo;

  logic              accept;
  logic              div_signed;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [2*XLEN-1:0] ext_a, ext_b, prod;
  logic [XLEN:0]     div_shift, div_diff;
  logic [XLEN-1:0]   quo_nxt, rem_nxt;
  logic              div_last;
  logic              div_by_zero;

  assign accept = req_valid && req_ready;

  // Operand conditioning at acceptance: magnitudes for signed divide
  always_comb begin
    div_signed = (req_op == OP_DIV);
    abs_a      = (div_signed && src_a[XLEN-1]) ? XLEN'(~src_a + XLEN'(1)) : src_a;
    abs_b      = (div_signed && src_b[XLEN-1]) ? XLEN'(~src_b + XLEN'(1)) : src_b;
  end

  // Full 64-bit product; sign- or zero-extension makes the low 64 bits exact
  always_comb begin
    ext_a = {{XLEN{is_signed & op_a[XLEN-1]}}, op_a};
    ext_b = {{XLEN{is_signed & op_b[XLEN-1]}}, op_b};
    prod  = ext_a * ext_b;
  end

  // One restoring radix-2 step; quo shifts out dividend bits and in quotient bits
  always_comb begin
    div_shift = {rem, quo[XLEN-1]};
    div_diff  = div_shift - {1'b0, dvsr};
    if (!div_diff[XLEN]) begin
      rem_nxt = div_diff[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = div_shift[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end
    div_last    = (cnt == CNTW'(XLEN - 1));
    div_by_zero = (op_b == '0);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake / write-port outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b0;
    hi_write  = 1'b0;
    lo_write  = 1'b0;
    hi_data   = src_a;
    lo_data   = src_a;

    req_ready = (state == S_IDLE) && !flush;
    busy      = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_MULT, OP_MULTU: state_nxt = S_MUL;
            OP_DIV, OP_DIVU:   state_nxt = S_DIV;
            OP_MTHI:           hi_write  = 1'b1;
            OP_MTLO:           lo_write  = 1'b1;
            default:           state_nxt = S_IDLE;
          endcase
        end
      end
      S_MUL:  state_nxt = S_DONE;
      S_DIV:  if (div_last) state_nxt = S_DONE;
      S_DONE: begin
        state_nxt = S_IDLE;
        hi_write  = !flush;
        lo_write  = !flush;
        hi_data   = res_hi;
        lo_data   = res_lo;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (flush && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  // Operand latches, divider iteration and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      is_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quo       <= '0;
      rem       <= '0;
      dvsr      <= '0;
      res_hi    <= '0;
      res_lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (req_op)
              OP_MULT, OP_MULTU: begin
                op_a      <= src_a;
                op_b      <= src_b;
                is_signed <= (req_op == OP_MULT);
              end
              OP_DIV, OP_DIVU: begin
                op_a      <= src_a;
                op_b      <= src_b;
                is_signed <= div_signed;
                neg_q     <= div_signed && (src_a[XLEN-1] ^ src_b[XLEN-1]);
                neg_r     <= div_signed && src_a[XLEN-1];
                quo       <= abs_a;
                dvsr      <= abs_b;
                rem       <= '0;
                cnt       <= '0;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          res_hi <= prod[2*XLEN-1:XLEN];
          res_lo <= prod[XLEN-1:0];
        end
        S_DIV: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt + CNTW'(1);
          if (div_last) begin
            if (div_by_zero) begin
              res_lo <= '1;
              res_hi <= op_a;
            end else begin
              res_lo <= neg_q ? XLEN'(~quo_nxt + XLEN'(1)) : quo_nxt;
              res_hi <= neg_r ? XLEN'(~rem_nxt + XLEN'(1)) : rem_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
